// File: rtl/fifo_rw_scheduler.sv
// FIFO scheduler that arbitrates write and read requests onto one single-port RAM.
// Define FIFO_SCHED_ALMOST_FLAGS_EN to add the almost_full/almost_empty outputs.
module fifo_rw_scheduler #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_req,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_req,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          wr_ack,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
`ifdef FIFO_SCHED_ALMOST_FLAGS_EN
  ,
  output logic          almost_full,
  output logic          almost_empty
`endif
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD      = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pri;

  logic wr_elig;
  logic rd_elig;
  logic grant_wr;
  logic grant_rd;

  // Occupancy flags decode straight from the registered count.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == CW'(0));

`ifdef FIFO_SCHED_ALMOST_FLAGS_EN
  assign almost_full  = (count >= CW'(DEPTH - 4));
  assign almost_empty = (count <= CW'(4));
`endif

  // Round-robin between write and read when both are eligible; pri=1 favours read.
  assign wr_elig  = wr_req && !full;
  assign rd_elig  = rd_req && !empty;
  assign grant_wr = wr_elig && (!rd_elig || !pri);
  assign grant_rd = rd_elig && (!wr_elig || pri);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      pri       <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      wr_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;

      case (state)
        IDLE: begin
          overflow  <= wr_req && full;
          underflow <= rd_req && empty;
          if (grant_wr) begin
            // RAM strobes are launched here so they are live for the whole WR cycle.
            state     <= WR;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wptr;
            mem_wdata <= wr_data;
            wr_ack    <= 1'b1;
            pri       <= 1'b1;
          end else if (grant_rd) begin
            state    <= RD;
            mem_en   <= 1'b1;
            mem_addr <= rptr;
            pri      <= 1'b0;
          end
        end

        WR: begin
          wptr  <= wptr + AW'(1);
          count <= count + CW'(1);
          state <= IDLE;
        end

        RD: begin
          state <= RD_WAIT;
        end

        RD_WAIT: begin
          // RAM data arrives one cycle after the RD strobe.
          rd_data  <= mem_rdata;
          rd_valid <= 1'b1;
          rptr     <= rptr + AW'(1);
          count    <= count - CW'(1);
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rw_scheduler.sv
// Directed self-checking bench for fifo_rw_scheduler with a behavioural single-port RAM.
module tb_fifo_rw_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_req = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_req = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_en, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       wr_ack;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty;
  logic [5:0] count;
  logic       overflow, underflow;
`ifdef FIFO_SCHED_ALMOST_FLAGS_EN
  logic       almost_full, almost_empty;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] ram [0:31];

  always #5 clk = ~clk;

  fifo_rw_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .mem_rdata (mem_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .wr_ack    (wr_ack),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef FIFO_SCHED_ALMOST_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // Single-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_req = 1'b0;
    rd_req = 1'b0;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
  endtask

  task automatic write_one(input logic [7:0] d);
    bit seen;
    seen    = 1'b0;
    wr_data = d;
    wr_req  = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (wr_ack) seen = 1'b1;
    end
    wr_req = 1'b0;
    total++;
    if (!seen) begin bad++; $display("FAIL write_ack_timeout: got no wr_ack want wr_ack for data %0h", d); end
  endtask

  task automatic read_one(output logic [7:0] d);
    bit seen;
    seen   = 1'b0;
    d      = 8'h00;
    rd_req = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (rd_valid) begin seen = 1'b1; d = rd_data; end
    end
    rd_req = 1'b0;
    total++;
    if (!seen) begin bad++; $display("FAIL read_valid_timeout: got no rd_valid want rd_valid"); end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (count !== 6'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags: got empty=%b full=%b want 1 0", empty, full); end
    total++; if ({mem_en, mem_we, wr_ack, rd_valid, overflow, underflow} !== 6'b0) begin
      bad++; $display("FAIL reset_pulses: got %b want 000000", {mem_en, mem_we, wr_ack, rd_valid, overflow, underflow});
    end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data: got %0h want 0", rd_data); end
  endtask

  task automatic test_single_wr_rd();
    do_reset();
    wr_data = 8'hA5;
    wr_req  = 1'b1;
    tick();
    wr_req  = 1'b0;
    total++; if ({wr_ack, mem_en, mem_we} !== 3'b111) begin bad++; $display("FAIL single_wr_strobes: got %b want 111", {wr_ack, mem_en, mem_we}); end
    total++; if (mem_addr !== 5'd0 || mem_wdata !== 8'hA5) begin bad++; $display("FAIL single_wr_bus: got addr=%0d data=%0h want 0 a5", mem_addr, mem_wdata); end
    tick();
    total++; if (wr_ack !== 1'b0 || count !== 6'd1 || empty !== 1'b0) begin
      bad++; $display("FAIL single_wr_after: got ack=%b count=%0d empty=%b want 0 1 0", wr_ack, count, empty);
    end
    rd_req = 1'b1;
    tick();
    total++; if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 5'd0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL single_rd_strobe: got en=%b we=%b addr=%0d valid=%b want 1 0 0 0", mem_en, mem_we, mem_addr, rd_valid);
    end
    tick();
    total++; if (rd_valid !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL single_rd_wait: got valid=%b en=%b want 0 0", rd_valid, mem_en); end
    tick();
    rd_req = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin bad++; $display("FAIL single_rd_data: got valid=%b data=%0h want 1 a5", rd_valid, rd_data); end
    total++; if (empty !== 1'b1 || count !== 6'd0) begin bad++; $display("FAIL single_rd_empty: got empty=%b count=%0d want 1 0", empty, count); end
    tick();
    total++; if (rd_valid !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL single_rd_pulse: got valid=%b uf=%b want 0 0", rd_valid, underflow); end
  endtask

  task automatic test_fill_overflow_wrap();
    logic [7:0] d;
    do_reset();
    for (int i = 1; i <= 32; i++) write_one(8'(i));
    tick();
    total++; if (count !== 6'd32 || full !== 1'b1) begin bad++; $display("FAIL fill_full: got count=%0d full=%b want 32 1", count, full); end
    wr_data = 8'h21;
    wr_req  = 1'b1;
    tick();
    total++; if (overflow !== 1'b1 || wr_ack !== 1'b0 || count !== 6'd32) begin
      bad++; $display("FAIL overflow_first: got of=%b ack=%b count=%0d want 1 0 32", overflow, wr_ack, count);
    end
    tick();
    total++; if (overflow !== 1'b1 || mem_en !== 1'b0) begin bad++; $display("FAIL overflow_repeat: got of=%b en=%b want 1 0", overflow, mem_en); end
    wr_req = 1'b0;
    tick();
    total++; if (overflow !== 1'b0 || count !== 6'd32) begin bad++; $display("FAIL overflow_clear: got of=%b count=%0d want 0 32", overflow, count); end
    for (int i = 1; i <= 32; i++) begin
      read_one(d);
      total++; if (d !== 8'(i)) begin bad++; $display("FAIL drain_data[%0d]: got %0h want %0h", i, d, 8'(i)); end
    end
    total++; if (empty !== 1'b1 || count !== 6'd0) begin bad++; $display("FAIL drain_empty: got empty=%b count=%0d want 1 0", empty, count); end
    for (int i = 0; i < 8; i++) begin
      write_one(8'h40 + 8'(i));
      total++; if (mem_addr !== 5'(i)) begin bad++; $display("FAIL wrap_waddr[%0d]: got %0d want %0d", i, mem_addr, i); end
      read_one(d);
      total++; if (d !== 8'h40 + 8'(i)) begin bad++; $display("FAIL wrap_data[%0d]: got %0h want %0h", i, d, 8'h40 + 8'(i)); end
    end
  endtask

  task automatic test_read_empty();
    do_reset();
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (underflow !== 1'b1 || rd_valid !== 1'b0 || mem_en !== 1'b0) begin
        bad++; $display("FAIL underflow[%0d]: got uf=%b valid=%b en=%b want 1 0 0", i, underflow, rd_valid, mem_en);
      end
    end
    rd_req = 1'b0;
    tick();
    total++; if (underflow !== 1'b0 || count !== 6'd0) begin bad++; $display("FAIL underflow_clear: got uf=%b count=%0d want 0 0", underflow, count); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] d;
    logic [7:0] rdv [2];
    string      seq;
    int         n;
    int         nr;
    do_reset();
    for (int i = 0; i < 6; i++) write_one(8'h10 + 8'(i));
    read_one(d);
    total++; if (d !== 8'h10 || count !== 6'd5) begin bad++; $display("FAIL simul_setup: got data=%0h count=%0d want 10 5", d, count); end
    seq     = "";
    n       = 0;
    nr      = 0;
    rdv[0]  = 8'h00;
    rdv[1]  = 8'h00;
    wr_data = 8'h55;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    for (int t = 0; t < 30 && n < 4; t++) begin
      tick();
      if (wr_ack) begin seq = {seq, "W"}; n++; end
      if (rd_valid) begin
        seq = {seq, "R"};
        n++;
        if (nr < 2) rdv[nr] = rd_data;
        nr++;
      end
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    total++; if (seq != "WRWR") begin bad++; $display("FAIL simul_order: got %s want WRWR", seq); end
    total++; if (rdv[0] !== 8'h11 || rdv[1] !== 8'h12) begin bad++; $display("FAIL simul_rdata: got %0h %0h want 11 12", rdv[0], rdv[1]); end
    total++; if (count !== 6'd5) begin bad++; $display("FAIL simul_count: got %0d want 5", count); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    write_one(8'h77);
    tick();
    rd_req = 1'b1;
    tick();
    tick();
    total++; if (rd_valid !== 1'b0 || mem_en !== 1'b0 || count !== 6'd1) begin
      bad++; $display("FAIL midrd_wait: got valid=%b en=%b count=%0d want 0 0 1", rd_valid, mem_en, count);
    end
    rd_req = 1'b0;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    total++; if (rd_valid !== 1'b0 || count !== 6'd0 || empty !== 1'b1) begin
      bad++; $display("FAIL midrd_reset: got valid=%b count=%0d empty=%b want 0 0 1", rd_valid, count, empty);
    end
    total++; if ({mem_en, mem_we, wr_ack, overflow, underflow} !== 5'b0 || rd_data !== 8'h00) begin
      bad++; $display("FAIL midrd_outputs: got %b data=%0h want 00000 0", {mem_en, mem_we, wr_ack, overflow, underflow}, rd_data);
    end
    tick();
    total++; if (rd_valid !== 1'b0 || count !== 6'd0) begin bad++; $display("FAIL midrd_after: got valid=%b count=%0d want 0 0", rd_valid, count); end
  endtask

`ifdef FIFO_SCHED_ALMOST_FLAGS_EN
  task automatic test_almost_flags();
    logic [7:0] d;
    do_reset();
    total++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      bad++; $display("FAIL almost_reset: got af=%b ae=%b want 0 1", almost_full, almost_empty);
    end
    for (int i = 0; i < 27; i++) write_one(8'(i));
    tick();
    total++; if (almost_full !== 1'b0 || count !== 6'd27) begin bad++; $display("FAIL almost_full_27: got af=%b count=%0d want 0 27", almost_full, count); end
    write_one(8'd27);
    tick();
    total++; if (almost_full !== 1'b1 || count !== 6'd28) begin bad++; $display("FAIL almost_full_28: got af=%b count=%0d want 1 28", almost_full, count); end
    for (int i = 0; i < 23; i++) read_one(d);
    total++; if (almost_empty !== 1'b0 || count !== 6'd5) begin bad++; $display("FAIL almost_empty_5: got ae=%b count=%0d want 0 5", almost_empty, count); end
    read_one(d);
    total++; if (almost_empty !== 1'b1 || count !== 6'd4) begin bad++; $display("FAIL almost_empty_4: got ae=%b count=%0d want 1 4", almost_empty, count); end
  endtask
`endif

  initial begin
    tick();
    test_reset();
    test_single_wr_rd();
    test_fill_overflow_wrap();
    test_read_empty();
    test_simultaneous();
    test_reset_mid_read();
`ifdef FIFO_SCHED_ALMOST_FLAGS_EN
    test_almost_flags();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
